// File: rtl/traffic_light_ctrl.sv
// Self-timed pedestrian-crossing controller.
// Phases are sequenced by an internal tick prescaler and a per-phase timer.
// The lamp bank is decoded from the next state and registered with the phase,
// so the lamps and phase always change on the same clock edge.
module traffic_light_ctrl #(
  parameter int unsigned TICK_DIV = 1,  // clock cycles per phase tick (>= 1)
  parameter int unsigned T_GREEN  = 6,  // minimum car-green ticks before serving a request
  parameter int unsigned T_YELLOW = 1,  // car-yellow ticks
  parameter int unsigned T_WALK   = 4,  // pedestrian-green ticks
  parameter int unsigned T_FLASH  = 5,  // blinking pedestrian-clearance ticks
  parameter int unsigned T_CLEAR  = 1   // all-red ticks before car green
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ped_req,
  input  logic       night_mode,
  output logic [4:0] luzes,
  output logic [2:0] phase,
  output logic       ped_wait
);

  // Largest phase duration sets the timer width; one spare bit guarantees no wrap.
  localparam int unsigned TMaxA  = (T_GREEN > T_YELLOW) ? T_GREEN : T_YELLOW;
  localparam int unsigned TMaxB  = (T_WALK > T_FLASH) ? T_WALK : T_FLASH;
  localparam int unsigned TMaxC  = (TMaxA > TMaxB) ? TMaxA : TMaxB;
  localparam int unsigned TMax   = (TMaxC > T_CLEAR) ? TMaxC : T_CLEAR;
  localparam int unsigned TimerW = $clog2(TMax) + 1;
  localparam int unsigned PreW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [TimerW-1:0] TGreen  = TimerW'(T_GREEN);
  localparam logic [TimerW-1:0] TYellow = TimerW'(T_YELLOW);
  localparam logic [TimerW-1:0] TWalk   = TimerW'(T_WALK);
  localparam logic [TimerW-1:0] TFlash  = TimerW'(T_FLASH);
  localparam logic [TimerW-1:0] TClear  = TimerW'(T_CLEAR);
  localparam logic [PreW-1:0]   PreLast = PreW'(TICK_DIV - 1);

  // Lamp bit order: car green, car yellow, car red, ped green, ped red.
  localparam logic [4:0] LampGreen  = 5'b10001;
  localparam logic [4:0] LampYellow = 5'b01001;
  localparam logic [4:0] LampWalk   = 5'b00110;
  localparam logic [4:0] LampFlashA = 5'b00100;
  localparam logic [4:0] LampAllRed = 5'b00101;
  localparam logic [4:0] LampNight  = 5'b01000;
  localparam logic [4:0] LampDark   = 5'b00000;

  typedef enum logic [2:0] {
    StGreen  = 3'd0,
    StYellow = 3'd1,
    StWalk   = 3'd2,
    StFlash  = 3'd3,
    StClear  = 3'd4,
    StNight  = 3'd5
  } phase_e;

  phase_e            phase_q, phase_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [PreW-1:0]   pre_q, pre_d;
  logic              blink_q, blink_d;
  logic              ped_wait_q, ped_wait_d;
  logic [4:0]        luzes_q, luzes_d;

  logic              tick;
  logic [TimerW-1:0] timer_inc;
  logic              req_window;

  // Prescaler: tick fires in the cycle where the counter is about to wrap.
  always_comb begin
    tick  = (pre_q == PreLast);
    pre_d = tick ? '0 : pre_q + PreW'(1);
  end

  // Phase sequencing: transitions and timer advance happen only on a tick.
  always_comb begin
    phase_d   = phase_q;
    timer_d   = timer_q;
    timer_inc = timer_q + TimerW'(1);
    if (tick) begin
      unique case (phase_q)
        StGreen: begin
          if (night_mode) begin
            phase_d = StNight;
          end else if (timer_inc >= TGreen) begin
            // Saturate so an unserved green can wait indefinitely without wrapping.
            timer_d = TGreen;
            if (ped_wait_q) phase_d = StYellow;
          end else begin
            timer_d = timer_inc;
          end
        end
        StYellow: begin
          timer_d = timer_inc;
          if (timer_inc == TYellow) phase_d = StWalk;
        end
        StWalk: begin
          timer_d = timer_inc;
          if (timer_inc == TWalk) phase_d = StFlash;
        end
        StFlash: begin
          timer_d = timer_inc;
          if (timer_inc == TFlash) phase_d = StClear;
        end
        StClear: begin
          timer_d = timer_inc;
          if (night_mode) begin
            phase_d = StNight;
          end else if (timer_inc == TClear) begin
            phase_d = StGreen;
          end
        end
        StNight: begin
          // Night duration is open-ended, so the timer is held rather than counted.
          timer_d = '0;
          if (!night_mode) phase_d = StClear;
        end
        default: phase_d = StGreen;
      endcase
    end
    if (phase_d != phase_q) timer_d = '0;
  end

  // Night blink: starts lit on entry, toggles per tick, parked low outside night.
  always_comb begin
    blink_d = blink_q;
    if (phase_d == StNight) begin
      if (phase_q != StNight) begin
        blink_d = 1'b1;
      end else if (tick) begin
        blink_d = ~blink_q;
      end
    end else begin
      blink_d = 1'b0;
    end
  end

  // Pedestrian latch: accept presses only while cars may still be stopped for them.
  always_comb begin
    req_window = (phase_q == StGreen) || (phase_q == StYellow) || (phase_q == StClear);
    ped_wait_d = ped_wait_q;
    if (ped_req && !night_mode && req_window) ped_wait_d = 1'b1;
    // Entering walk serves the request; this wins over a same-cycle press.
    if ((phase_d == StWalk) && (phase_q != StWalk)) ped_wait_d = 1'b0;
  end

  // Lamp decode from next state so lamps register alongside the phase.
  always_comb begin
    luzes_d = LampGreen;
    unique case (phase_d)
      StGreen:  luzes_d = LampGreen;
      StYellow: luzes_d = LampYellow;
      StWalk:   luzes_d = LampWalk;
      StFlash:  luzes_d = timer_d[0] ? LampAllRed : LampFlashA;
      StClear:  luzes_d = LampAllRed;
      StNight:  luzes_d = blink_d ? LampNight : LampDark;
      default:  luzes_d = LampGreen;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= StGreen;
      timer_q    <= '0;
      pre_q      <= '0;
      blink_q    <= 1'b0;
      ped_wait_q <= 1'b0;
      luzes_q    <= LampGreen;
    end else begin
      phase_q    <= phase_d;
      timer_q    <= timer_d;
      pre_q      <= pre_d;
      blink_q    <= blink_d;
      ped_wait_q <= ped_wait_d;
      luzes_q    <= luzes_d;
    end
  end

  assign luzes    = luzes_q;
  assign phase    = phase_q;
  assign ped_wait = ped_wait_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: two instances (tick every cycle, tick every 4 cycles)
// driven by shared inputs and compared each cycle against a behavioural model.
module tb_traffic_light_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ped_req = 1'b0;
  logic       night_mode = 1'b0;
  logic [4:0] luzes1, luzes4;
  logic [2:0] phase1, phase4;
  logic       wait1, wait4;

  int checks = 0;
  int failures = 0;

  traffic_light_ctrl #(.TICK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ped_req(ped_req), .night_mode(night_mode),
    .luzes(luzes1), .phase(phase1), .ped_wait(wait1)
  );

  traffic_light_ctrl #(.TICK_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .ped_req(ped_req), .night_mode(night_mode),
    .luzes(luzes4), .phase(phase4), .ped_wait(wait4)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached (actual=running required=finished)");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural model ----------------
  // Phases: 0 green, 1 yellow, 2 walk, 3 flash, 4 clear, 5 night.
  int dur[5] = '{6, 1, 4, 5, 1};
  int div[2] = '{1, 4};
  int m_phase[2];
  int m_ticks[2];
  int m_pre[2];
  bit m_wait[2];
  bit m_blink[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = 0; m_ticks[k] = 0; m_pre[k] = 0; m_wait[k] = 0; m_blink[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input bit req, input bit night);
    bit tick;
    bit old_wait;
    int np;
    tick = (m_pre[k] == div[k] - 1);
    m_pre[k] = tick ? 0 : m_pre[k] + 1;
    old_wait = m_wait[k];
    np = m_phase[k];
    if (req && !night && (m_phase[k] == 0 || m_phase[k] == 1 || m_phase[k] == 4))
      m_wait[k] = 1;
    if (tick) begin
      case (m_phase[k])
        0: begin
          if (night) np = 5;
          else begin
            m_ticks[k] = (m_ticks[k] + 1 > dur[0]) ? dur[0] : m_ticks[k] + 1;
            if (m_ticks[k] >= dur[0] && old_wait) np = 1;
          end
        end
        1, 2, 3: begin
          m_ticks[k]++;
          if (m_ticks[k] == dur[m_phase[k]]) np = m_phase[k] + 1;
        end
        4: begin
          if (night) np = 5;
          else begin
            m_ticks[k]++;
            if (m_ticks[k] == dur[4]) np = 0;
          end
        end
        default: begin
          if (!night) np = 4;
          else m_blink[k] = !m_blink[k];
        end
      endcase
    end
    if (np != m_phase[k]) begin
      m_ticks[k] = 0;
      if (np == 5) m_blink[k] = 1;
      if (np == 2) m_wait[k] = 0;
      m_phase[k] = np;
    end
  endtask

  function automatic logic [4:0] model_lamps(input int k);
    case (m_phase[k])
      0: return 5'b10001;
      1: return 5'b01001;
      2: return 5'b00110;
      3: return (m_ticks[k] % 2 == 1) ? 5'b00101 : 5'b00100;
      4: return 5'b00101;
      default: return m_blink[k] ? 5'b01000 : 5'b00000;
    endcase
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("m1_luzes", 32'(luzes1), 32'(model_lamps(0)));
    chk("m1_phase", 32'(phase1), 32'(m_phase[0]));
    chk("m1_wait", 32'(wait1), 32'(m_wait[0]));
    chk("m4_luzes", 32'(luzes4), 32'(model_lamps(1)));
    chk("m4_phase", 32'(phase4), 32'(m_phase[1]));
    chk("m4_wait", 32'(wait4), 32'(m_wait[1]));
  endtask

  // One clock: advance model with current inputs, clock the DUTs, compare after the edge.
  task automatic step();
    model_step(0, ped_req, night_mode);
    model_step(1, ped_req, night_mode);
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    ped_req = 0;
    night_mode = 0;
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  typedef struct {
    bit         req;
    bit         night;
    logic [4:0] luz;
    logic [2:0] ph;
    bit         w;
  } vec_t;

  vec_t tbl[18];

  initial begin
    int ent[6];
    int walk_cnt;
    int green_re;
    int yellow2;
    int prev;
    int guard;
    bit seen;

    // Single press sampled at edge 3; expected state after each edge 1..18.
    tbl[0]  = '{0, 0, 5'b10001, 3'd0, 0};
    tbl[1]  = '{0, 0, 5'b10001, 3'd0, 0};
    tbl[2]  = '{1, 0, 5'b10001, 3'd0, 1};
    tbl[3]  = '{0, 0, 5'b10001, 3'd0, 1};
    tbl[4]  = '{0, 0, 5'b10001, 3'd0, 1};
    tbl[5]  = '{0, 0, 5'b01001, 3'd1, 1};
    tbl[6]  = '{0, 0, 5'b00110, 3'd2, 0};
    tbl[7]  = '{0, 0, 5'b00110, 3'd2, 0};
    tbl[8]  = '{0, 0, 5'b00110, 3'd2, 0};
    tbl[9]  = '{0, 0, 5'b00110, 3'd2, 0};
    tbl[10] = '{0, 0, 5'b00100, 3'd3, 0};
    tbl[11] = '{0, 0, 5'b00101, 3'd3, 0};
    tbl[12] = '{0, 0, 5'b00100, 3'd3, 0};
    tbl[13] = '{0, 0, 5'b00101, 3'd3, 0};
    tbl[14] = '{0, 0, 5'b00100, 3'd3, 0};
    tbl[15] = '{0, 0, 5'b00101, 3'd4, 0};
    tbl[16] = '{0, 0, 5'b10001, 3'd0, 0};
    tbl[17] = '{0, 0, 5'b10001, 3'd0, 0};

    // Reset state, then idle: green must hold with no request.
    do_reset();
    chk("reset_luzes", 32'(luzes1), 32'h11);
    chk("reset_phase", 32'(phase1), 32'h0);
    chk("reset_wait", 32'(wait1), 32'h0);
    for (int i = 0; i < 50; i++) begin
      step();
      chk("idle_luzes", 32'(luzes1), 32'h11);
      chk("idle_phase", 32'(phase1), 32'h0);
    end

    // Table-driven single crossing on the tick-every-cycle instance.
    do_reset();
    for (int i = 0; i < 18; i++) begin
      ped_req = tbl[i].req;
      night_mode = tbl[i].night;
      step();
      chk($sformatf("tbl%0d_luzes", i + 1), 32'(luzes1), 32'(tbl[i].luz));
      chk($sformatf("tbl%0d_phase", i + 1), 32'(phase1), 32'(tbl[i].ph));
      chk($sformatf("tbl%0d_wait", i + 1), 32'(wait1), 32'(tbl[i].w));
    end

    // Prescaled instance: same pulse, every phase entry lands 4x later.
    do_reset();
    for (int p = 0; p < 6; p++) ent[p] = -1;
    prev = 0;
    for (int e = 1; e <= 80; e++) begin
      ped_req = (e == 3);
      step();
      if (int'(phase4) != prev) begin
        if (ent[phase4] < 0) ent[phase4] = e;
        prev = int'(phase4);
      end
    end
    chk("div4_yellow_entry", ent[1], 24);
    chk("div4_walk_entry", ent[2], 28);
    chk("div4_flash_entry", ent[3], 44);
    chk("div4_clear_entry", ent[4], 64);
    chk("div4_green_reentry", ent[0], 68);

    // Held request: one crossing, latch re-arms via clear, next yellow T_GREEN later.
    do_reset();
    ped_req = 1;
    walk_cnt = 0; green_re = -1; yellow2 = -1; prev = 0;
    for (int e = 1; e <= 30; e++) begin
      step();
      if (int'(phase1) == 2 && prev != 2 && e <= 22) walk_cnt++;
      if (int'(phase1) == 0 && prev == 4 && green_re < 0) green_re = e;
      if (int'(phase1) == 1 && prev == 0 && green_re > 0 && yellow2 < 0) yellow2 = e;
      if (e == 16) chk("held_wait_in_clear", 32'(wait1), 32'h0);
      if (e == 17) chk("held_wait_rearmed", 32'(wait1), 32'h1);
      prev = int'(phase1);
    end
    ped_req = 0;
    chk("held_walk_count", walk_cnt, 1);
    chk("held_green_reentry", green_re, 17);
    chk("held_yellow_gap", yellow2 - green_re, 6);

    // Night requested during walk: crossing completes, then blinking yellow.
    do_reset();
    ped_req = 1;
    step();
    ped_req = 0;
    guard = 0;
    while (phase1 != 3'd2 && guard < 40) begin step(); guard++; end
    chk("night_reach_walk", 32'(phase1), 32'h2);
    night_mode = 1;
    guard = 0; prev = int'(phase1);
    while (phase1 != 3'd5 && guard < 40) begin prev = int'(phase1); step(); guard++; end
    chk("night_prev_phase", prev, 4);
    chk("night_lamp0", 32'(luzes1), 32'h08);
    step(); chk("night_lamp1", 32'(luzes1), 32'h00);
    step(); chk("night_lamp2", 32'(luzes1), 32'h08);
    step(); chk("night_lamp3", 32'(luzes1), 32'h00);
    night_mode = 0;
    step();
    chk("night_exit_phase", 32'(phase1), 32'h4);
    chk("night_exit_luzes", 32'(luzes1), 32'h05);
    step();
    chk("night_green_luzes", 32'(luzes1), 32'h11);

    // Asynchronous reset mid-flash clears both instances without a clock edge.
    do_reset();
    ped_req = 1;
    step();
    ped_req = 0;
    guard = 0;
    while (phase1 != 3'd3 && guard < 40) begin step(); guard++; end
    step();
    chk("arst_pre_phase", 32'(phase1), 32'h3);
    chk("arst_pre_wait4", 32'(wait4), 32'h1);
    #3;
    rst_n = 0;
    #1;
    chk("arst_luzes", 32'(luzes1), 32'h11);
    chk("arst_phase", 32'(phase1), 32'h0);
    chk("arst_wait1", 32'(wait1), 32'h0);
    chk("arst_wait4", 32'(wait4), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    ped_req = 1;
    step();
    ped_req = 0;
    seen = 0;
    for (int e = 0; e < 30; e++) begin
      step();
      if (phase1 == 3'd2) seen = 1;
    end
    chk("arst_resume_walk", 32'(seen), 32'h1);

    // Randomized traffic against the model, with occasional night and resets.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      ped_req = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 149) == 0) night_mode = !night_mode;
      if ($urandom_range(0, 999) == 0) do_reset();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
